// File: rtl/rc6_pkg.sv
// Shared constants, state encoding and rotate helper for the RC6-32 key schedule.
package rc6_pkg;

  localparam logic [31:0] P32 = 32'hB7E15163;
  localparam logic [31:0] Q32 = 32'h9E3779B9;

  localparam int T_WORDS   = 44;
  localparam int MIX_STEPS = 132;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    MIX,
    DONE
  } ks_state_e;

  // Rotate left by the low five bits; doubling the word keeps a zero rotate a pass-through.
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] d;
    d = {x, x} << n;
    return d[63:32];
  endfunction

endpackage

// File: rtl/rc6_ks_step.sv
// One RC6 key-schedule mixing step: combines S[i], L[j] and the running A/B pair.
module rc6_ks_step
  import rc6_pkg::*;
(
  input  logic [31:0] s_i,
  input  logic [31:0] l_j,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] a_next,
  output logic [31:0] b_next
);

  logic [31:0] a_sum;
  logic [31:0] ab_sum;

  // A' depends only on the old A/B, then B' is rotated by the low bits of A'+B.
  always_comb begin
    a_sum  = s_i + a + b;
    a_next = rotl32(a_sum, 5'd3);
    ab_sum = a_next + b;
    b_next = rotl32(l_j + ab_sum, ab_sum[4:0]);
  end

endmodule

// File: rtl/rc6_key_schedule.sv
// RC6-32/r/b key schedule controller: loads the user key, fills S from the magic
// constants, runs the mixing loop one step per clock and serves S through a read port.
module rc6_key_schedule
  import rc6_pkg::*;
#(
  parameter int KEY_WORDS = 4,
  parameter int ROUNDS    = 20
)
(
  input  logic                    inClk,
  input  logic                    inRstN,
  input  logic                    inStart,
  input  logic [32*KEY_WORDS-1:0] inKey,
  input  logic [5:0]              inRkAddr,
  output logic [31:0]             outRk,
  output logic                    outBusy,
  output logic                    outKeyValid,
  output logic                    outDone
);

  localparam int T     = 2 * ROUNDS + 4;
  localparam int STEPS = 3 * ((KEY_WORDS > T) ? KEY_WORDS : T);

  localparam logic [5:0] I_LAST    = 6'(T - 1);
  localparam logic [2:0] J_LAST    = 3'(KEY_WORDS - 1);
  localparam logic [7:0] STEP_LAST = 8'(STEPS - 1);

  ks_state_e state;

  logic [31:0]       s_mem [0:T-1];
  logic [7:0][31:0]  l_mem;

  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [5:0]  i_idx;
  logic [2:0]  j_idx;
  logic [7:0]  step;

  logic busy_q;
  logic valid_q;
  logic done_q;

  logic [31:0] a_next;
  logic [31:0] b_next;

  logic accept_start;

  assign accept_start = (state == IDLE) && inStart;

  rc6_ks_step u_step (
    .s_i    (s_mem[i_idx]),
    .l_j    (l_mem[j_idx]),
    .a      (a_reg),
    .b      (b_reg),
    .a_next (a_next),
    .b_next (b_next)
  );

  // Control FSM: sequences load, INIT fill and MIX loop, and registers the status outputs.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      i_idx   <= '0;
      j_idx   <= '0;
      step    <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (inStart) begin
            state   <= INIT;
            i_idx   <= 6'd1;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        INIT: begin
          if (i_idx == I_LAST) begin
            state <= MIX;
            i_idx <= '0;
            j_idx <= '0;
            a_reg <= '0;
            b_reg <= '0;
            step  <= '0;
          end else begin
            i_idx <= i_idx + 6'd1;
          end
        end
        MIX: begin
          a_reg <= a_next;
          b_reg <= b_next;
          i_idx <= (i_idx == I_LAST) ? 6'd0 : i_idx + 6'd1;
          j_idx <= (j_idx == J_LAST) ? 3'd0 : j_idx + 3'd1;
          step  <= step + 8'd1;
          if (step == STEP_LAST) begin
            state   <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // S/L storage carries no reset; it is only meaningful once the FSM has produced valid keys.
  always_ff @(posedge inClk) begin
    if (accept_start) begin
      s_mem[0]               <= P32;
      l_mem[KEY_WORDS-1:0]   <= inKey;
    end else if (state == INIT) begin
      s_mem[i_idx] <= s_mem[i_idx - 6'd1] + Q32;
    end else if (state == MIX) begin
      s_mem[i_idx] <= a_next;
      l_mem[j_idx] <= b_next;
    end
  end

  assign outRk       = (inRkAddr < 6'(T)) ? s_mem[inRkAddr] : 32'd0;
  assign outBusy     = busy_q;
  assign outKeyValid = valid_q;
  assign outDone     = done_q;

endmodule

// File: tb/tb_rc6_key_schedule.sv
// Self-checking bench for rc6_key_schedule: 128/192/256-bit builds against a software RC6 model.
module tb_rc6_key_schedule;

  logic        clk;
  logic        rst_n;
  logic        start   [3];
  logic [255:0] key_bus [3];
  logic [5:0]  addr    [3];
  logic [31:0] rk      [3];
  logic        busy    [3];
  logic        valid   [3];
  logic        done    [3];

  int checks;
  int errors;

  typedef struct {
    int                d;
    int                kw;
    logic [255:0]      key;
    logic [43:0][31:0] exp_s;
    string             tag;
  } vec_t;

  vec_t vecs[5];

  rc6_key_schedule #(.KEY_WORDS(4), .ROUNDS(20)) dut4 (
    .inClk(clk), .inRstN(rst_n), .inStart(start[0]), .inKey(key_bus[0][127:0]),
    .inRkAddr(addr[0]), .outRk(rk[0]), .outBusy(busy[0]), .outKeyValid(valid[0]), .outDone(done[0])
  );

  rc6_key_schedule #(.KEY_WORDS(6), .ROUNDS(20)) dut6 (
    .inClk(clk), .inRstN(rst_n), .inStart(start[1]), .inKey(key_bus[1][191:0]),
    .inRkAddr(addr[1]), .outRk(rk[1]), .outBusy(busy[1]), .outKeyValid(valid[1]), .outDone(done[1])
  );

  rc6_key_schedule #(.KEY_WORDS(8), .ROUNDS(20)) dut8 (
    .inClk(clk), .inRstN(rst_n), .inStart(start[2]), .inKey(key_bus[2]),
    .inRkAddr(addr[2]), .outRk(rk[2]), .outBusy(busy[2]), .outKeyValid(valid[2]), .outDone(done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    if (n == 0) return x;
    return (x << n) | (x >> (32 - n));
  endfunction

  // Straight software RC6 key expansion, c key words, r = 20.
  function automatic logic [43:0][31:0] ks_model(input logic [255:0] key, input int c);
    logic [31:0] s [44];
    logic [31:0] l [8];
    logic [31:0] a;
    logic [31:0] b;
    logic [43:0][31:0] r;
    int i;
    int j;
    for (int w = 0; w < 8; w++) l[w] = key[32*w +: 32];
    s[0] = 32'hB7E15163;
    for (int k = 1; k < 44; k++) s[k] = s[k-1] + 32'h9E3779B9;
    a = 0;
    b = 0;
    i = 0;
    j = 0;
    for (int v = 0; v < 3 * 44; v++) begin
      a    = rol(s[i] + a + b, 3);
      s[i] = a;
      b    = rol(l[j] + a + b, int'((a + b) % 32));
      l[j] = b;
      i    = (i + 1) % 44;
      j    = (j + 1) % c;
    end
    for (int k = 0; k < 44; k++) r[k] = s[k];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Starts a run on instance d; optional extra start pulses (pa/pb) and a reset abort cycle.
  task automatic applyStimulus(input int d, input logic [255:0] key, input int pa, input int pb,
                               input int abort_at, output int cyc);
    int busy_bad;
    bit aborted;
    busy_bad = 0;
    aborted  = 0;
    @(negedge clk);
    start[d]   = 1'b1;
    key_bus[d] = key;
    @(negedge clk);
    start[d]   = 1'b0;
    key_bus[d] = ~key;
    cyc = 1;
    checkOutput("valid low after start", 32'(valid[d]), 32'd0);
    while (done[d] !== 1'b1 && cyc < 400) begin
      if (cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 32'(busy[d]), 32'd0);
        checkOutput("abort valid", 32'(valid[d]), 32'd0);
        checkOutput("abort done", 32'(done[d]), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        aborted = 1;
        break;
      end
      if (busy[d] !== 1'b1) busy_bad++;
      start[d] = (cyc == pa || cyc == pb);
      @(negedge clk);
      cyc++;
    end
    start[d] = 1'b0;
    if (!aborted) begin
      checkOutput("busy window", 32'(busy_bad), 32'd0);
      checkOutput("busy low at done", 32'(busy[d]), 32'd0);
      checkOutput("valid at done", 32'(valid[d]), 32'd1);
      @(negedge clk);
      checkOutput("done one cycle", 32'(done[d]), 32'd0);
      checkOutput("valid held", 32'(valid[d]), 32'd1);
    end
  endtask

  task automatic checkKeys(input int d, input logic [43:0][31:0] exp_s, input string tag);
    for (int a = 0; a < 44; a++) begin
      addr[d] = 6'(a);
      #1;
      checkOutput($sformatf("%s S[%0d]", tag, a), rk[d], exp_s[a]);
    end
  endtask

  initial begin
    int cyc;
    logic [255:0] k;
    checks = 0;
    errors = 0;
    for (int d = 0; d < 3; d++) begin
      start[d]   = 1'b0;
      key_bus[d] = '0;
      addr[d]    = '0;
    end

    vecs[0] = '{0, 4, 256'h0, '0, "zero128"};
    vecs[1] = '{1, 6, 256'h0123456789abcdef0112233445566778899aabbccddeeff0, '0, "key192"};
    vecs[2] = '{2, 8, 256'h0123456789abcdef0112233445566778899aabbccddeeff01032547698badcfe, '0, "key256"};
    vecs[3] = '{0, 4, 256'h000102030405060708090a0b0c0d0e0f, '0, "ramp128"};
    vecs[4] = '{1, 6, 256'hffffffffffffffffffffffffffffffffffffffffffffffff, '0, "ones192"};
    for (int v = 0; v < 5; v++) vecs[v].exp_s = ks_model(vecs[v].key, vecs[v].kw);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy[0]), 32'd0);
    checkOutput("reset valid", 32'(valid[0]), 32'd0);
    checkOutput("reset done", 32'(done[0]), 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].d, vecs[v].key, -1, -1, -1, cyc);
      checkOutput({vecs[v].tag, " latency"}, 32'(cyc), 32'd176);
      checkKeys(vecs[v].d, vecs[v].exp_s, vecs[v].tag);
    end

    k = 256'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    applyStimulus(0, k, 50, 150, -1, cyc);
    checkOutput("ignored starts latency", 32'(cyc), 32'd176);
    checkKeys(0, ks_model(k, 4), "ignored starts");

    applyStimulus(0, 256'hdeadbeefcafef00d1234567890abcdef, -1, -1, 90, cyc);
    k = 256'h55aa55aa33cc33cc0ff00ff012345678;
    applyStimulus(0, k, -1, -1, -1, cyc);
    checkOutput("post abort latency", 32'(cyc), 32'd176);
    checkKeys(0, ks_model(k, 4), "post abort");

    checkOutput("valid before restart", 32'(valid[0]), 32'd1);
    k = 256'h89abcdef01234567fedcba9876543210;
    applyStimulus(0, k, -1, -1, -1, cyc);
    checkOutput("restart latency", 32'(cyc), 32'd176);
    checkKeys(0, ks_model(k, 4), "restart");
    addr[0] = 6'd50;
    #1;
    checkOutput("addr 50 reads zero", rk[0], 32'd0);

    for (int n = 0; n < 100; n++) begin
      for (int w = 0; w < 8; w++) k[32*w +: 32] = $urandom;
      applyStimulus(2, k, -1, -1, -1, cyc);
      checkOutput("rand256 latency", 32'(cyc), 32'd176);
      checkKeys(2, ks_model(k, 8), $sformatf("rand256 #%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
